// File: rtl/lbp_engine_if.sv
// lbp_engine_if: gray-memory read port and LBP write port of lbp_engine.
// Ports: gray_ready/gray_req/gray_addr/gray_data (read side, 1-cycle latency),
//        lbp_valid/lbp_addr/lbp_data (write strobe), finish (sticky done).
interface lbp_engine_if #(
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8
);
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [PIX_W-1:0]  gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;
  logic              finish;

  // Engine side.
  modport master (
    input  gray_ready, gray_data,
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );

  // Memory / sink side.
  modport slave (
    output gray_ready, gray_data,
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );
endinterface

// File: rtl/lbp_engine.sv
// lbp_engine: 3x3 local binary pattern over a raster gray image, one code per
// interior pixel. Ports: clk, reset (async, active-high), bus (lbp_engine_if.master).
// Reads stall while gray_ready=0; optional macro LBP_BORDER_ZERO_EN adds zero codes for border pixels.
module lbp_engine #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic         clk,
  input  logic         reset,
  lbp_engine_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, ROW_FILL, COL_READ, EMIT, DONE, B_TOP, B_LEFT, B_RIGHT, B_BOT
  } state_t;

  // Address offsets, all in ADDR_W bits. pix_q always holds y*IMG_W+x.
  localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_START = ADDR_W'(IMG_W + 1);     // pix -> (x-1, y-1)
  localparam logic [ADDR_W-1:0] W_M1      = ADDR_W'(IMG_W - 1);     // pix -> (x+1, y-1)
  localparam logic [ADDR_W-1:0] W_M2      = ADDR_W'(IMG_W - 2);     // pix -> (x+2, y-1)
  localparam logic [ADDR_W-1:0] NXT_COL   = ADDR_W'(2 * IMG_W - 1); // bottom of col -> top of next
  localparam logic [ADDR_W-1:0] XMAX      = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] YMAX      = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] THREE     = ADDR_W'(3);
`ifdef LBP_BORDER_ZERO_EN
  localparam logic [ADDR_W-1:0] TWO       = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(IMG_W * IMG_H - 1);
`endif

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]       pix_q, pix_d;
  logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    cap_vld_q, cap_vld_d;
  logic [1:0]              cap_slot_q, cap_slot_d;
  logic [8:0][PIX_W-1:0]   win_q, win_d;   // index r*3+c, r=0 top row, c=2 newest column
  logic                    lbp_valid_q, lbp_valid_d;
  logic [ADDR_W-1:0]       lbp_addr_q, lbp_addr_d;
  logic [7:0]              lbp_data_q, lbp_data_d;
  logic                    finish_q, finish_d;
`ifdef LBP_BORDER_ZERO_EN
  logic [ADDR_W-1:0]       bord_q, bord_d;
`endif

  logic       rd_fire;
  logic [1:0] rd_slot;
  logic [7:0] code;

  // A read is issued only when the memory is ready; a stalled read simply
  // repeats next cycle with the same address and counters.
  assign rd_fire = ((state_q == ROW_FILL) || (state_q == COL_READ)) && bus.gray_ready;

  // Row within the column being read (ROW_FILL reads two columns of three).
  always_comb begin
    case (cnt_q)
      3'd0, 3'd3: rd_slot = 2'd0;
      3'd1, 3'd4: rd_slot = 2'd1;
      default:    rd_slot = 2'd2;
    endcase
  end

  // Capture the data returned for last cycle's read. The top pixel of each
  // column arrives first, so that is the moment to shift the window left.
  always_comb begin
    win_d = win_q;
    if (cap_vld_q) begin
      if (cap_slot_q == 2'd0) begin
        for (int r = 0; r < 3; r++) begin
          win_d[r*3+0] = win_q[r*3+1];
          win_d[r*3+1] = win_q[r*3+2];
        end
      end
      case (cap_slot_q)
        2'd0:    win_d[2] = bus.gray_data;
        2'd1:    win_d[5] = bus.gray_data;
        default: win_d[8] = bus.gray_data;
      endcase
    end
  end

  // EMIT directly follows the last column read, so the bottom-right pixel is
  // only available through win_d in that cycle.
  always_comb begin
    code[0] = (win_d[0] >= win_d[4]);  // TL
    code[1] = (win_d[1] >= win_d[4]);  // T
    code[2] = (win_d[2] >= win_d[4]);  // TR
    code[3] = (win_d[3] >= win_d[4]);  // L
    code[4] = (win_d[5] >= win_d[4]);  // R
    code[5] = (win_d[6] >= win_d[4]);  // BL
    code[6] = (win_d[7] >= win_d[4]);  // B
    code[7] = (win_d[8] >= win_d[4]);  // BR
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pix_d       = pix_q;
    rd_addr_d   = rd_addr_q;
    cnt_d       = cnt_q;
    cap_vld_d   = rd_fire;
    cap_slot_d  = rd_slot;
    lbp_valid_d = 1'b0;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    finish_d    = finish_q | (state_q == DONE);
`ifdef LBP_BORDER_ZERO_EN
    bord_d      = bord_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.gray_ready) begin
`ifdef LBP_BORDER_ZERO_EN
          state_d = B_TOP;
          bord_d  = '0;
`else
          state_d   = ROW_FILL;
          rd_addr_d = pix_q - ROW_START;
          cnt_d     = '0;
`endif
        end
      end
      ROW_FILL: begin
        if (rd_fire) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            state_d   = COL_READ;
            cnt_d     = '0;
            rd_addr_d = pix_q - W_M1;
          end else if (cnt_q == 3'd2) begin
            rd_addr_d = rd_addr_q - NXT_COL;
          end else begin
            rd_addr_d = rd_addr_q + W_A;
          end
        end
      end
      COL_READ: begin
        if (rd_fire) begin
          if (cnt_q == 3'd2) begin
            state_d = EMIT;
            cnt_d   = '0;
          end else begin
            cnt_d     = cnt_q + 3'd1;
            rd_addr_d = rd_addr_q + W_A;
          end
        end
      end
      EMIT: begin
        lbp_valid_d = 1'b1;
        lbp_addr_d  = pix_q;
        lbp_data_d  = code;
        if (x_q < XMAX) begin
          x_d       = x_q + ONE;
          pix_d     = pix_q + ONE;
          state_d   = COL_READ;
          rd_addr_d = pix_q - W_M2;
        end else begin
`ifdef LBP_BORDER_ZERO_EN
          state_d = B_RIGHT;
`else
          if (y_q < YMAX) begin
            y_d       = y_q + ONE;
            x_d       = ONE;
            pix_d     = pix_q + THREE;
            state_d   = ROW_FILL;
            rd_addr_d = pix_q - W_M2;   // (1, y+1) - IMG_W - 1
          end else begin
            state_d = DONE;
          end
`endif
        end
      end
`ifdef LBP_BORDER_ZERO_EN
      B_TOP: begin
        lbp_valid_d = 1'b1;
        lbp_addr_d  = bord_q;
        lbp_data_d  = '0;
        if (bord_q == W_M1) state_d = B_LEFT;
        else                bord_d  = bord_q + ONE;
      end
      B_LEFT: begin
        lbp_valid_d = 1'b1;
        lbp_addr_d  = pix_q - ONE;
        lbp_data_d  = '0;
        state_d     = ROW_FILL;
        rd_addr_d   = pix_q - ROW_START;
        cnt_d       = '0;
      end
      B_RIGHT: begin
        lbp_valid_d = 1'b1;
        lbp_addr_d  = pix_q + ONE;
        lbp_data_d  = '0;
        if (y_q < YMAX) begin
          y_d     = y_q + ONE;
          x_d     = ONE;
          pix_d   = pix_q + THREE;
          state_d = B_LEFT;
        end else begin
          state_d = B_BOT;
          bord_d  = pix_q + TWO;       // (0, IMG_H-1)
        end
      end
      B_BOT: begin
        lbp_valid_d = 1'b1;
        lbp_addr_d  = bord_q;
        lbp_data_d  = '0;
        if (bord_q == LAST) state_d = DONE;
        else                bord_d  = bord_q + ONE;
      end
`endif
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= ONE;
      y_q         <= ONE;
      pix_q       <= ROW_START;
      rd_addr_q   <= '0;
      cnt_q       <= '0;
      cap_vld_q   <= 1'b0;
      cap_slot_q  <= '0;
      win_q       <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      finish_q    <= 1'b0;
`ifdef LBP_BORDER_ZERO_EN
      bord_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_q       <= pix_d;
      rd_addr_q   <= rd_addr_d;
      cnt_q       <= cnt_d;
      cap_vld_q   <= cap_vld_d;
      cap_slot_q  <= cap_slot_d;
      win_q       <= win_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
      finish_q    <= finish_d;
`ifdef LBP_BORDER_ZERO_EN
      bord_q      <= bord_d;
`endif
    end
  end

  assign bus.gray_req  = rd_fire;
  assign bus.gray_addr = rd_addr_q;
  assign bus.lbp_valid = lbp_valid_q;
  assign bus.lbp_addr  = lbp_addr_q;
  assign bus.lbp_data  = lbp_data_q;
  assign bus.finish    = finish_q;

endmodule

// File: tb/tb_lbp_engine.sv
// tb_lbp_engine: directed bench for lbp_engine on a 5x4 and a 3x3 image.
// Ports: none; drives clk/reset and two lbp_engine_if instances with memory models.
// Memory models answer every gray_req with one cycle of latency.
module tb_lbp_engine;
  localparam int AW = 5, AH = 4, AAW = 5;
  localparam int BW = 3, BAW = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lbp_engine_if #(.ADDR_W(AAW), .PIX_W(PW)) bus_a ();
  lbp_engine_if #(.ADDR_W(BAW), .PIX_W(PW)) bus_b ();

  lbp_engine #(.IMG_W(AW), .IMG_H(AH), .PIX_W(PW), .ADDR_W(AAW)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  lbp_engine #(.IMG_W(BW), .IMG_H(BW), .PIX_W(PW), .ADDR_W(BAW)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  logic [7:0] mem_a [AW*AH];
  logic [7:0] mem_b [BW*BW];

  always @(posedge clk) if (bus_a.gray_req) bus_a.gray_data <= mem_a[bus_a.gray_addr];
  always @(posedge clk) if (bus_b.gray_req) bus_b.gray_data <= mem_b[bus_b.gray_addr];

  // Observation, sampled on the falling edge.
  int rd_a = 0, viol_a = 0, oob_a = 0, cyc_cnt = 0;
  int obs_addr[$], obs_data[$], obs_time[$];
  int cnt_b = 0, hit4_b = 0, data4_b = 0;

  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (!reset) begin
      if (bus_a.gray_req) begin
        rd_a <= rd_a + 1;
        if (int'(bus_a.gray_addr) >= AW*AH) oob_a <= oob_a + 1;
      end
      if (!bus_a.gray_ready && bus_a.gray_req) viol_a <= viol_a + 1;
      if (bus_a.lbp_valid) begin
        obs_addr.push_back(int'(bus_a.lbp_addr));
        obs_data.push_back(int'(bus_a.lbp_data));
        obs_time.push_back(cyc_cnt);
      end
      if (bus_b.lbp_valid) begin
        cnt_b <= cnt_b + 1;
        if (bus_b.lbp_addr == 4'd4) begin
          hit4_b  <= hit4_b + 1;
          data4_b <= int'(bus_b.lbp_data);
        end
      end
    end
  end

  int n_chk = 0, n_fail = 0;
  int exp_addr[$], exp_data[$];
  int last_start = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bit k set when neighbour k >= centre; k = TL,T,TR,L,R,BL,B,BR.
  function automatic int golden_a(input int x, input int y);
    int dx[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int dy[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int c = int'(mem_a[y*AW + x]);
    int code = 0;
    for (int k = 0; k < 8; k++)
      if (int'(mem_a[(y+dy[k])*AW + x + dx[k]]) >= c) code |= (1 << k);
    return code;
  endfunction

  task automatic build_exp();
    exp_addr.delete();
    exp_data.delete();
    for (int y = 0; y < AH; y++)
      for (int x = 0; x < AW; x++) begin
        if (x == 0 || y == 0 || x == AW-1 || y == AH-1) begin
`ifdef LBP_BORDER_ZERO_EN
          exp_addr.push_back(y*AW + x);
          exp_data.push_back(0);
`endif
        end else begin
          exp_addr.push_back(y*AW + x);
          exp_data.push_back(golden_a(x, y));
        end
      end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus_a.gray_ready = 1'b0;
    bus_b.gray_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_a(input string tag, input bit stall);
    int cyc = 0;
    int start, rd0, v0, o0;
    do_reset();
    start = obs_addr.size();
    last_start = start;
    rd0 = rd_a; v0 = viol_a; o0 = oob_a;
    while (bus_a.finish !== 1'b1 && cyc < 3000) begin
      bus_a.gray_ready = stall ? (((cyc / 3) % 2) == 1) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    bus_a.gray_ready = 1'b0;
    chk({tag, "_finish"}, int'(bus_a.finish), 1);
    build_exp();
    chk({tag, "_count"}, obs_addr.size() - start, exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i),
          (start + i < obs_addr.size()) ? obs_addr[start+i] : -1, exp_addr[i]);
      chk($sformatf("%s_data%0d", tag, i),
          (start + i < obs_data.size()) ? obs_data[start+i] : -1, exp_data[i]);
    end
    chk({tag, "_reads"}, rd_a - rd0, 2 * (6 + 3 * (AW - 2)));
    chk({tag, "_req_wo_ready"}, viol_a - v0, 0);
    chk({tag, "_addr_range"}, oob_a - o0, 0);
`ifndef LBP_BORDER_ZERO_EN
    if (!stall)
      chk({tag, "_cadence"},
          (obs_time.size() > start + 1) ? obs_time[start+1] - obs_time[start] : -1, 4);
`endif
  endtask

  initial begin
    int start, cyc;
    bus_a.gray_ready = 1'b1;
    bus_b.gray_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state, with gray_ready high.
    chk("rst_gray_req",  int'(bus_a.gray_req), 0);
    chk("rst_gray_addr", int'(bus_a.gray_addr), 0);
    chk("rst_lbp_valid", int'(bus_a.lbp_valid), 0);
    chk("rst_lbp_addr",  int'(bus_a.lbp_addr), 0);
    chk("rst_lbp_data",  int'(bus_a.lbp_data), 0);
    chk("rst_finish",    int'(bus_a.finish), 0);
    #1 reset = 1'b0;
    bus_a.gray_ready = 1'b0;

    // 3x3 image: 99 100 101 / 0 100 255 / 100 50 200.
    // Neighbour >= 100: T,TR,R,BL,BR -> bits 1,2,4,5,7 -> 0xB6.
    mem_b = '{8'd99, 8'd100, 8'd101, 8'd0, 8'd100, 8'd255, 8'd100, 8'd50, 8'd200};
    cyc = 0;
    while (bus_b.finish !== 1'b1 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b3_finish", int'(bus_b.finish), 1);
    chk("b3_hit4", hit4_b, 1);
    chk("b3_code", data4_b, 8'hB6);
`ifdef LBP_BORDER_ZERO_EN
    chk("b3_count", cnt_b, 9);
`else
    chk("b3_count", cnt_b, 1);
`endif

    // Flat image: every comparison is equal, so all interior codes are 0xFF.
    for (int i = 0; i < AW*AH; i++) mem_a[i] = 8'h55;
    run_a("flat", 1'b0);

    // Finish is sticky and nothing more is written.
    start = obs_addr.size();
    repeat (10) @(posedge clk);
    #1;
    chk("sticky_finish", int'(bus_a.finish), 1);
    chk("sticky_no_strobe", obs_addr.size() - start, 0);

    // Random image, then the same image with gray_ready toggling every 3 cycles.
    for (int i = 0; i < AW*AH; i++) mem_a[i] = 8'($urandom_range(0, 255));
    mem_a[7] = mem_a[6];   // force an equal neighbour pair
    run_a("rand", 1'b0);
    run_a("stall", 1'b1);

    // Abandon an image part way, then rerun it from the start.
    do_reset();
    bus_a.gray_ready = 1'b1;
    start = obs_addr.size();
    cyc = 0;
    while (obs_addr.size() < start + 2 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_two_strobes", obs_addr.size() - start, 2);
    chk("mid_not_finished", int'(bus_a.finish), 0);
    run_a("rerun", 1'b0);
`ifdef LBP_BORDER_ZERO_EN
    chk("rerun_first_addr", (obs_addr.size() > last_start) ? obs_addr[last_start] : -1, 0);
`else
    chk("rerun_first_addr", (obs_addr.size() > last_start) ? obs_addr[last_start] : -1, AW + 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
